// File: rtl/hp_glitch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hp_glitch_seq : Wishbone-programmed glitch campaign sequencer, hp detector |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hp_glitch_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned CLR_CYC    = 4
) (
  input  logic        wb_clk_i,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_stl_o,
  output logic [31:0] wbs_dat_o,
  output logic        hp_vcc,
  output logic        hp_Alarm_rst,
  output logic        hp_Alarm_ctr_rst,
  output logic        hp_glitch_en,
  output logic        glitch,
  input  logic        hp_Alarm,
  input  logic        hp_Alarm_latch,
  input  logic [7:0]  hp_Alarm_ctr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POWER = 3'd1,
    S_CLEAR = 3'd2,
    S_ARM   = 3'd3,
    S_PULSE = 3'd4,
    S_WAIT  = 3'd5,
    S_GAP   = 3'd6,
    S_CHECK = 3'd7
  } state_t;

  localparam logic [7:0]  c_settle_last = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]  c_clr_last    = 8'(CLR_CYC - 1);
  localparam logic [31:0] c_cfg_reset   = 32'h1008_0401;
  localparam logic [31:0] c_top_addr    = BASE_ADDR + 32'h0000_000F;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_issued;
  logic [7:0]  r_caught;
  logic [7:0]  r_missed;
  logic [7:0]  r_snap;
  logic        r_done;
  logic        r_mismatch;
  logic        r_latch_dbg;
  logic        r_vcc;
  logic        r_alarm_rst;
  logic        r_ctr_rst;
  logic        r_glitch_en;
  logic        r_glitch;

  logic [31:0] r_cfg;
  logic        r_vcc_hold;
  logic        r_ack;
  logic [31:0] r_dat;

  logic        w_hit;
  logic        w_req;
  logic        w_wr;
  logic        w_sel_ctrl;
  logic        w_sel_cfg;
  logic        w_sel_stat;
  logic        w_start;
  logic        w_abort;
  logic        w_busy;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic [7:0]  w_width_last;
  logic [7:0]  w_gap_last;
  logic [7:0]  w_timeout_last;
  logic [7:0]  w_count;

  // 16-byte window: CTRL, CFG, STATUS, and a reserved word that reads as zero
  assign w_hit      = (wbs_adr_i >= BASE_ADDR) && (wbs_adr_i <= c_top_addr);
  assign w_req      = wbs_cyc_i && wbs_stb_i && w_hit && !r_ack;
  assign w_wr       = w_req && wbs_we_i;
  assign w_sel_ctrl = (wbs_adr_i[31:2] == BASE_ADDR[31:2]);
  assign w_sel_cfg  = (wbs_adr_i[31:2] == (BASE_ADDR[31:2] + 30'd1));
  assign w_sel_stat = (wbs_adr_i[31:2] == (BASE_ADDR[31:2] + 30'd2));
  assign w_abort    = w_wr && w_sel_ctrl && wbs_dat_i[1];
  assign w_start    = w_wr && w_sel_ctrl && wbs_dat_i[0] && !wbs_dat_i[1];
  assign w_busy     = (r_state != S_IDLE);

  assign w_width_last   = (r_cfg[7:0]   == 8'd0) ? 8'd0 : r_cfg[7:0]   - 8'd1;
  assign w_gap_last     = (r_cfg[15:8]  == 8'd0) ? 8'd0 : r_cfg[15:8]  - 8'd1;
  assign w_count        = r_cfg[23:16];
  assign w_timeout_last = (r_cfg[31:24] == 8'd0) ? 8'd0 : r_cfg[31:24] - 8'd1;

  assign w_status = {r_snap, r_missed, r_caught, 4'b0000,
                     r_latch_dbg, r_mismatch, r_done, w_busy};

  always_comb begin
    w_rdata = 32'h0;
    if (w_sel_ctrl)      w_rdata[2] = r_vcc_hold;
    else if (w_sel_cfg)  w_rdata    = r_cfg;
    else if (w_sel_stat) w_rdata    = w_status;
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ack      <= 1'b0;
      r_dat      <= 32'h0;
      r_cfg      <= c_cfg_reset;
      r_vcc_hold <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_rdata : 32'h0;
      if (w_wr && w_sel_ctrl)
        r_vcc_hold <= wbs_dat_i[2];
      if (w_wr && w_sel_cfg && !w_busy)
        r_cfg <= wbs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_issued    <= 8'd0;
      r_caught    <= 8'd0;
      r_missed    <= 8'd0;
      r_snap      <= 8'd0;
      r_done      <= 1'b0;
      r_mismatch  <= 1'b0;
      r_latch_dbg <= 1'b0;
      r_vcc       <= 1'b0;
      r_alarm_rst <= 1'b0;
      r_ctr_rst   <= 1'b0;
      r_glitch_en <= 1'b0;
      r_glitch    <= 1'b0;
    end else if (w_abort && w_busy) begin
      // the aborting write also carries the new vcc_hold value
      r_state     <= S_IDLE;
      r_vcc       <= wbs_dat_i[2];
      r_alarm_rst <= 1'b0;
      r_ctr_rst   <= 1'b0;
      r_glitch_en <= 1'b0;
      r_glitch    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_vcc <= r_vcc_hold;
          if (w_start) begin
            r_caught   <= 8'd0;
            r_missed   <= 8'd0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_cnt      <= c_settle_last;
            r_vcc      <= 1'b1;
            r_state    <= S_POWER;
          end
        end
        S_POWER: begin
          if (r_cnt == 8'd0) begin
            r_cnt       <= c_clr_last;
            r_alarm_rst <= 1'b1;
            r_ctr_rst   <= 1'b1;
            r_state     <= S_CLEAR;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == 8'd0) begin
            r_alarm_rst <= 1'b0;
            r_ctr_rst   <= 1'b0;
            r_glitch_en <= 1'b1;
            r_state     <= S_ARM;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ARM: begin
          if (w_count != 8'd0) begin
            r_glitch <= 1'b1;
            r_cnt    <= w_width_last;
            r_issued <= 8'd1;
            r_state  <= S_PULSE;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_PULSE: begin
          if (r_cnt == 8'd0) begin
            r_glitch <= 1'b0;
            r_cnt    <= w_timeout_last;
            r_state  <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_WAIT: begin
          if (hp_Alarm || (r_cnt == 8'd0)) begin
            if (hp_Alarm) r_caught <= r_caught + 8'd1;
            else          r_missed <= r_missed + 8'd1;
            r_alarm_rst <= 1'b1;
            r_cnt       <= w_gap_last;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_GAP: begin
          r_alarm_rst <= 1'b0;
          if (r_cnt == 8'd0) begin
            if (r_issued < w_count) begin
              r_glitch <= 1'b1;
              r_cnt    <= w_width_last;
              r_issued <= r_issued + 8'd1;
              r_state  <= S_PULSE;
            end else begin
              r_state <= S_CHECK;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CHECK: begin
          r_snap      <= hp_Alarm_ctr;
          r_mismatch  <= (hp_Alarm_ctr != r_caught);
          r_latch_dbg <= hp_Alarm_latch;
          r_done      <= 1'b1;
          r_glitch_en <= 1'b0;
          r_vcc       <= r_vcc_hold;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o        = r_ack;
  assign wbs_stl_o        = 1'b0;
  assign wbs_dat_o        = r_dat;
  assign hp_vcc           = r_vcc;
  assign hp_Alarm_rst     = r_alarm_rst;
  assign hp_Alarm_ctr_rst = r_ctr_rst;
  assign hp_glitch_en     = r_glitch_en;
  assign glitch           = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_hp_glitch_seq.sv
`default_nettype none
// Bench for hp_glitch_seq: a detector model on the falling clock edge answers
// glitches and records pulse/wait/gap lengths for the scenario tasks to check.
module tb_hp_glitch_seq;

  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o, wbs_stl_o;
  logic [31:0] wbs_dat_o;
  logic        hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch;
  logic        hp_Alarm = 1'b0;
  logic        hp_Alarm_latch = 1'b0;
  logic [7:0]  hp_Alarm_ctr = 8'd0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_snap = 8'd0;

  logic [255:0] det_mask = '0;
  int  det_delay = 2;
  bit  det_stuck = 1'b0;
  int  cd = 0, pidx = 0, hcnt = 0, wcnt = 0, gcnt = 0;
  bit  wflag = 1'b0, gflag = 1'b0, prev_glitch = 1'b0, prev_rst = 1'b0;
  int  q_width[$];
  int  q_wait[$];
  int  q_gap[$];

  hp_glitch_seq dut (
    .wb_clk_i(clk), .reset_n(reset_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_stl_o(wbs_stl_o), .wbs_dat_o(wbs_dat_o),
    .hp_vcc(hp_vcc), .hp_Alarm_rst(hp_Alarm_rst), .hp_Alarm_ctr_rst(hp_Alarm_ctr_rst),
    .hp_glitch_en(hp_glitch_en), .glitch(glitch),
    .hp_Alarm(hp_Alarm), .hp_Alarm_latch(hp_Alarm_latch), .hp_Alarm_ctr(hp_Alarm_ctr)
  );

  always #5 clk = ~clk;

  // Detector model: alarm det_delay cycles after a selected glitch falls.
  always @(negedge clk) begin
    hp_Alarm = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        hp_Alarm = 1'b1;
        if (!(det_stuck && hp_Alarm_ctr >= 8'd1)) hp_Alarm_ctr = hp_Alarm_ctr + 8'd1;
      end
    end
    if (hp_Alarm_ctr_rst) begin
      hp_Alarm_ctr = 8'd0; pidx = 0; cd = 0; wflag = 1'b0; gflag = 1'b0;
    end
    if (hp_Alarm) hp_Alarm_latch = 1'b1;
    if (hp_Alarm_rst) hp_Alarm_latch = 1'b0;
    if (prev_glitch && !glitch) begin
      if (pidx < 256 && det_mask[pidx]) cd = det_delay;
      pidx++;
      q_width.push_back(hcnt);
      hcnt = 0; wflag = 1'b1; wcnt = 0;
    end else if (wflag) begin
      wcnt++;
      if (hp_Alarm_rst) begin q_wait.push_back(wcnt); wflag = 1'b0; end
    end
    if (glitch) hcnt++;
    if (hp_Alarm_rst && !prev_rst && hp_glitch_en) begin
      gflag = 1'b1; gcnt = 0;
    end else if (gflag) begin
      gcnt++;
      if (glitch) begin q_gap.push_back(gcnt); gflag = 1'b0; end
    end
    if (!hp_glitch_en) gflag = 1'b0;
    prev_glitch = glitch;
    prev_rst = hp_Alarm_rst;
  end

  function automatic logic [31:0] model_status(int cnt, int t_eff, logic [255:0] mask,
                                               int d, bit stuck);
    int c = 0;
    int ctr;
    for (int i = 0; i < cnt; i++)
      if (mask[i] && (d + 1 <= t_eff)) c++;
    ctr = stuck ? ((c > 0) ? 1 : 0) : c;
    return {8'(ctr), 8'(cnt - c), 8'(c), 5'b00000, (ctr != c), 1'b1, 1'b0};
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic acked);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat;
    acked = 1'b0; rdat = 32'h0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin acked = 1'b1; rdat = wbs_dat_o; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic run_campaign(input logic [31:0] cfg, output logic [31:0] status,
                              output bit timed_out);
    logic [31:0] rd;
    logic ack;
    q_width.delete(); q_wait.delete(); q_gap.delete();
    wb_xfer(1'b1, BASE + 32'h4, cfg, rd, ack);
    wb_xfer(1'b1, BASE, 32'h1, rd, ack);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, ack);
      if (ack && !rd[0]) begin timed_out = 1'b0; break; end
    end
    status = rd;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ack;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000",
               {hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch});
    end
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_stl_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_wb: ack=%b stl=%b dat=%h required 0 0 0", wbs_ack_o, wbs_stl_o, wbs_dat_o);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, rd, ack);
    checks++;
    if (!ack || rd !== 32'h1008_0401) begin
      errors++; $display("FAIL reset_cfg: ack=%b got %h required 10080401", ack, rd);
    end
    wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, ack);
    checks++;
    if (!ack || rd !== 32'h0) begin
      errors++; $display("FAIL reset_status: ack=%b got %h required 00000000", ack, rd);
    end
    wb_xfer(1'b0, BASE, 32'h0, rd, ack);
    checks++;
    if (!ack || rd !== 32'h0) begin
      errors++; $display("FAIL reset_ctrl: ack=%b got %h required 00000000", ack, rd);
    end
  endtask

  task automatic test_nominal();
    logic [31:0] st;
    bit to;
    det_mask = '1; det_delay = 2; det_stuck = 1'b0;
    run_campaign(32'h1006_0302, st, to);
    checks++;
    if (to) begin errors++; $display("FAIL nominal_timeout: busy never cleared"); end
    checks++;
    if (st !== 32'h0600_0602) begin
      errors++; $display("FAIL nominal_status: got %h required 06000602", st);
    end
    checks++;
    if (q_width.size() != 6) begin
      errors++; $display("FAIL nominal_pulses: got %0d required 6", q_width.size());
    end
    foreach (q_width[i]) begin
      checks++;
      if (q_width[i] != 2) begin
        errors++; $display("FAIL nominal_width[%0d]: got %0d required 2", i, q_width[i]);
      end
    end
    foreach (q_wait[i]) begin
      checks++;
      if (q_wait[i] != 3) begin
        errors++; $display("FAIL nominal_wait[%0d]: got %0d required 3", i, q_wait[i]);
      end
    end
    checks++;
    if (q_gap.size() != 5) begin
      errors++; $display("FAIL nominal_gaps: got %0d required 5", q_gap.size());
    end
    foreach (q_gap[i]) begin
      checks++;
      if (q_gap[i] != 3) begin
        errors++; $display("FAIL nominal_gap[%0d]: got %0d required 3", i, q_gap[i]);
      end
    end
    exp_snap = 8'd6;
  endtask

  task automatic test_missed();
    logic [31:0] st;
    bit to;
    int exp_wait[5] = '{2, 3, 2, 3, 2};
    det_mask = 256'b10101; det_delay = 1; det_stuck = 1'b0;
    run_campaign(32'h0305_0101, st, to);
    checks++;
    if (to || st !== 32'h0302_0302) begin
      errors++; $display("FAIL missed_status: timeout=%0d got %h required 03020302", to, st);
    end
    checks++;
    if (q_wait.size() != 5) begin
      errors++; $display("FAIL missed_waits: got %0d required 5", q_wait.size());
    end
    foreach (q_wait[i]) begin
      checks++;
      if (i < 5 && q_wait[i] != exp_wait[i]) begin
        errors++; $display("FAIL missed_wait[%0d]: got %0d required %0d", i, q_wait[i], exp_wait[i]);
      end
    end
    exp_snap = 8'd3;
  endtask

  task automatic test_mismatch();
    logic [31:0] st;
    bit to;
    det_mask = '1; det_delay = 2; det_stuck = 1'b1;
    run_campaign(32'h1004_0101, st, to);
    checks++;
    if (to || st !== 32'h0100_0406) begin
      errors++; $display("FAIL mismatch_status: timeout=%0d got %h required 01000406", to, st);
    end
    det_stuck = 1'b0;
    exp_snap = 8'd1;
  endtask

  task automatic test_edges();
    logic [31:0] st, rd;
    bit to;
    logic ack;
    det_mask = '1; det_delay = 2;
    run_campaign(32'h1000_0201, st, to);
    checks++;
    if (to || st !== 32'h0000_0002) begin
      errors++; $display("FAIL count0_status: timeout=%0d got %h required 00000002", to, st);
    end
    checks++;
    if (q_width.size() != 0) begin
      errors++; $display("FAIL count0_pulses: got %0d required 0", q_width.size());
    end
    exp_snap = 8'd0;
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, rd, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL unmapped_ack: got %b required 0", ack); end
    wb_xfer(1'b0, BASE + 32'hC, 32'h0, rd, ack);
    checks++;
    if (ack !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL reserved_read: ack=%b data=%h required 1 00000000", ack, rd);
    end
    wb_xfer(1'b1, BASE, 32'h4, rd, ack);
    @(posedge clk); #1;
    checks++;
    if ({hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch} !== 5'b10000) begin
      errors++;
      $display("FAIL vcc_hold_on: got %b required 10000",
               {hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch});
    end
    wb_xfer(1'b0, BASE, 32'h0, rd, ack);
    checks++;
    if (!ack || rd !== 32'h4) begin
      errors++; $display("FAIL ctrl_read: ack=%b got %h required 00000004", ack, rd);
    end
    wb_xfer(1'b1, BASE, 32'h0, rd, ack);
    @(posedge clk); #1;
    checks++;
    if (hp_vcc !== 1'b0) begin errors++; $display("FAIL vcc_hold_off: got %b required 0", hp_vcc); end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic ack;
    bit got;
    det_mask = '1; det_delay = 2;
    wb_xfer(1'b1, BASE + 32'h4, 32'h0408_01C8, rd, ack);
    wb_xfer(1'b1, BASE, 32'h1, rd, ack);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (glitch === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL abort_pulse_start: glitch=%b required 1", glitch); end
    wb_xfer(1'b1, BASE, 32'h1, rd, ack);
    checks++;
    if (glitch !== 1'b1) begin
      errors++; $display("FAIL busy_start: glitch=%b required 1", glitch);
    end
    wb_xfer(1'b1, BASE + 32'h4, 32'h1234_5678, rd, ack);
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'h0408_01C8) begin
      errors++; $display("FAIL busy_cfg_write: got %h required 040801c8", rd);
    end
    wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, ack);
    checks++;
    if (rd !== {exp_snap, 24'h000001}) begin
      errors++; $display("FAIL busy_status: got %h required %h", rd, {exp_snap, 24'h000001});
    end
    wb_xfer(1'b1, BASE, 32'h3, rd, ack);
    checks++;
    if ({hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch} !== 5'b0) begin
      errors++;
      $display("FAIL abort_outputs: got %b required 00000",
               {hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch});
    end
    wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, ack);
    checks++;
    if (rd !== {exp_snap, 24'h0}) begin
      errors++; $display("FAIL abort_status: got %h required %h", rd, {exp_snap, 24'h0});
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (glitch !== 1'b0 || hp_glitch_en !== 1'b0) begin
      errors++; $display("FAIL abort_stays_idle: glitch=%b en=%b required 0 0", glitch, hp_glitch_en);
    end
  endtask

  task automatic test_random();
    logic [31:0] st, exp;
    logic [7:0] w, g, c, t;
    logic [255:0] mask;
    int te, we, ge, d;
    bit stuck, to;
    for (int n = 0; n < 6; n++) begin
      w = 8'($urandom_range(0, 3)); g = 8'($urandom_range(0, 3));
      c = 8'($urandom_range(0, 6)); t = 8'($urandom_range(0, 6));
      te = (t == 0) ? 1 : int'(t);
      we = (w == 0) ? 1 : int'(w);
      ge = (g == 0) ? 1 : int'(g);
      if (te >= 2) begin
        d = $urandom_range(1, te - 1);
        mask = {224'b0, 32'($urandom)};
      end else begin
        d = 1;
        mask = '0;
      end
      stuck = 1'($urandom_range(0, 1));
      det_mask = mask; det_delay = d; det_stuck = stuck;
      exp = model_status(int'(c), te, mask, d, stuck);
      run_campaign({t, c, g, w}, st, to);
      checks++;
      if (to || st !== exp) begin
        errors++;
        $display("FAIL rand%0d_status: cfg=%h timeout=%0d got %h required %h", n, {t, c, g, w}, to, st, exp);
      end
      checks++;
      if (q_width.size() != int'(c) || q_wait.size() != int'(c)) begin
        errors++;
        $display("FAIL rand%0d_pulses: widths=%0d waits=%0d required %0d", n, q_width.size(), q_wait.size(), c);
      end
      foreach (q_width[i]) begin
        checks++;
        if (q_width[i] != we) begin
          errors++; $display("FAIL rand%0d_width[%0d]: got %0d required %0d", n, i, q_width[i], we);
        end
      end
      foreach (q_wait[i]) begin
        checks++;
        if (q_wait[i] != (mask[i] ? d + 1 : te)) begin
          errors++;
          $display("FAIL rand%0d_wait[%0d]: got %0d required %0d", n, i, q_wait[i], mask[i] ? d + 1 : te);
        end
      end
      foreach (q_gap[i]) begin
        checks++;
        if (q_gap[i] != ge) begin
          errors++; $display("FAIL rand%0d_gap[%0d]: got %0d required %0d", n, i, q_gap[i], ge);
        end
      end
      exp_snap = exp[31:24];
    end
    det_stuck = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic ack;
    bit got;
    det_mask = '1; det_delay = 2;
    wb_xfer(1'b1, BASE + 32'h4, 32'h1006_0302, rd, ack);
    wb_xfer(1'b1, BASE, 32'h1, rd, ack);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (glitch === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL areset_pulse_start: glitch=%b required 1", glitch); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch} !== 5'b0) begin
      errors++;
      $display("FAIL areset_outputs: got %b required 00000",
               {hp_vcc, hp_Alarm_rst, hp_Alarm_ctr_rst, hp_glitch_en, glitch});
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, ack);
    checks++;
    if (!ack || rd !== 32'h0) begin
      errors++; $display("FAIL areset_status: ack=%b got %h required 00000000", ack, rd);
    end
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, rd, ack);
    checks++;
    if (!ack || rd !== 32'h1008_0401) begin
      errors++; $display("FAIL areset_cfg: ack=%b got %h required 10080401", ack, rd);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_missed();
    test_mismatch();
    test_edges();
    test_abort();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
